wb_team_interconnect: RTL and testbench
=======================================

# wb_team_interconnect

Registered Wishbone slave-side interconnect between the Caravel host bus and the per-team design wrappers plus the LA control and GPIO control blocks. Scales to NUM_TEAMS designs and decodes a 4-bit slave field from the address. Holds each transaction in a small state machine and forwards exactly one ack per host cycle. Unmapped addresses and hung slaves are answered with an error word instead of stalling the management core.

## Interface
- NUM_TEAMS, 1: number of team designs, legal range 1..13; slave codes 1..NUM_TEAMS.
- TIMEOUT_CYCLES, 255: BUSY cycles before a forced error ack; must be ≥ 2.
- ERR_DATA, 32'hDEAD_BEEF: value of wbs_dat_o on any error ack.

Ports:
- wb_clk_i  in  1  bus clock; all state changes on the rising edge.
- wb_rst_ni  in  1  asynchronous reset, active-low.
- wbs_cyc_i  in  1  host cycle valid.
- wbs_stb_i  in  1  host strobe.
- wbs_adr_i  in  32  host address.
- wbs_ack_o  out  1  ack to host, registered.
- wbs_dat_o  out  32  read data to host, registered.
- designs_stb  out  NUM_TEAMS+1  per-team strobe; bit 0 is reserved and tied 0.
- la_control_stb  out  1  strobe to LA control.
- gpio_control_stb  out  1  strobe to GPIO control.
- adr_truncated  out  32  {16'h0, latched adr[15:0]}.
- designs_wbs_dat_o_flat  in  32*(NUM_TEAMS+1)  team read data; slot i is at [32i +: 32].
- designs_ack_o  in  NUM_TEAMS+1  team acks; bit 0 is ignored.
- la_control_dat_o, gpio_control_dat_o  in  32 each  control-block read data.
- la_control_ack_o, gpio_control_ack_o  in  1 each  control-block acks.
- timeout_irq_o  out  1  one-cycle pulse on each timeout.

## Operation
- Slave code s = adr[19:16]:
  - 1..NUM_TEAMS selects that team.
  - 4'hE selects LA control.
  - 4'hF selects GPIO control.
  - Any other code is unmapped.
  - adr[31:20] is not decoded.
- State IDLE:
  - All downstream strobes are 0.
  - On cyc&stb with a mapped s: latch s and adr[15:0], go to BUSY.
  - On cyc&stb with an unmapped s: load ERR_DATA, go to ACK.
- State BUSY:
  - Exactly one strobe is asserted, decoded from the latched s.
  - adr_truncated holds the latched address.
  - Selected slave acks: register its dat into wbs_dat_o, go to ACK.
  - cyc_i falls: abort to IDLE with no ack and data unchanged.
  - Timeout counter reaches TIMEOUT_CYCLES: load ERR_DATA, pulse timeout_irq_o, go to ACK.
- State ACK:
  - wbs_ack_o = 1 for exactly one cycle, then IDLE unconditionally.
- Acks from non-selected slaves are ignored in every state.
- Reset values:
  - state = IDLE.
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - All strobes = 0, adr_truncated = 0, timeout_irq_o = 0, counter = 0.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously); no ack is issued.

## Timing
- Host request sampled at edge N: slave strobe is visible in cycle N+1.
- Slave ack at edge M: wbs_ack_o is high in cycle M+1, with data valid the same cycle.
- Minimum host latency for a zero-wait slave: 2 cycles, stb to ack.
- Unmapped access: ack is high the cycle after the request is sampled.
- Timeout counter:
  - Cleared on entry to BUSY; counts each BUSY cycle.
  - Expiry is TIMEOUT_CYCLES cycles after BUSY entry; ack follows one cycle later.
- Slave ack and timeout expiry in the same cycle: the slave ack wins; real data is returned and no irq pulse is issued.
- Slave ack and cyc_i falling in the same cycle: abort wins; no ack is issued.
- The host holds stb until ack. A new request is accepted only in IDLE, so back-to-back transactions are spaced by at least one IDLE cycle.

## Configuration
- WB_TIMEOUT_EN defined:
  - The timeout counter, the error-ack-on-timeout path and timeout_irq_o are present as described above.
- WB_TIMEOUT_EN undefined:
  - No counter is built; BUSY waits indefinitely for the slave ack or for cyc_i to fall.
  - timeout_irq_o is tied 0.
  - Unmapped-address error acks are still generated.

## Test plan
- Reset with stimulus active: assert wb_rst_ni low while cyc=stb=1 → all outputs 0; after release, state is IDLE.
- Team read: NUM_TEAMS=3, adr=32'h3003_0010, team 3 acks 1 cycle after its stb with 32'h1234_5678 → designs_stb=4'b1000, adr_truncated=32'h0000_0010, wbs_ack_o high for exactly 1 cycle with dat=32'h1234_5678.
- Control blocks and unmapped:
  - adr=32'h300F_0004 → only gpio_control_stb asserts.
  - adr=32'h3000_0000 (code 0) → no strobe; ack next cycle with dat=32'hDEAD_BEEF.
- Timeout: TIMEOUT_CYCLES=8, selected team never acks → ack 9 cycles after BUSY entry with dat=ERR_DATA and a single timeout_irq_o pulse. With WB_TIMEOUT_EN undefined: no ack after 1000 cycles.
- Simultaneous events:
  - Slave ack coincident with timeout expiry → real data returned, irq stays 0.
  - cyc_i dropped in BUSY → strobe falls next cycle, no ack.
- Stray acks: team 2 acks while team 1 is selected → ignored; the transaction completes only on team 1's ack.

Source files
------------

// File: rtl/wb_team_interconnect.sv
// -----------------------------------------------------------------------------
// wb_team_interconnect
//
// Registered Wishbone slave-side interconnect between the host bus and the
// per-team design wrappers, the LA control block and the GPIO control block.
// The slave is chosen by the 4-bit code in wbs_adr_i[19:16]:
//   1..NUM_TEAMS -> team design, 4'hE -> LA control, 4'hF -> GPIO control,
//   anything else is unmapped and answered with an ERR_DATA error ack.
// A transaction is held in a small FSM.  Exactly one registered ack is
// returned per host cycle, unless the host drops cyc first.
//
// Optional feature (macro WB_TIMEOUT_EN):
//   defined   : a BUSY timeout counter forces an ERR_DATA ack after
//               TIMEOUT_CYCLES and pulses timeout_irq_o.
//   undefined : no counter; BUSY waits for the slave ack or for cyc to fall;
//               timeout_irq_o is tied 0.
//
// Ports:
//   wb_clk_i, wb_rst_ni         bus clock, asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i        host cycle / strobe
//   wbs_adr_i                   host address
//   wbs_ack_o, wbs_dat_o        registered ack and read data to the host
//   designs_stb                 per-team strobes (bit 0 reserved, always 0)
//   la_control_stb              strobe to LA control
//   gpio_control_stb            strobe to GPIO control
//   adr_truncated               {16'h0, latched adr[15:0]}
//   designs_wbs_dat_o_flat      team read data, slot i at [32*i +: 32]
//   designs_ack_o               team acks (bit 0 ignored)
//   la_control_dat_o/_ack_o     LA control read data / ack
//   gpio_control_dat_o/_ack_o   GPIO control read data / ack
//   timeout_irq_o               one-cycle pulse on each timeout
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; strobes low; waiting for cyc & stb
// ST_BUSY | slave selected, its strobe high; waiting for ack/abort/timeout
// ST_ACK  | wbs_ack_o high for this single cycle, then back to ST_IDLE
// -----------------------------------------------------------------------------
module wb_team_interconnect #(
   parameter int unsigned NUM_TEAMS      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_ni,
   input  logic                          wbs_cyc_i,
   input  logic                          wbs_stb_i,
   input  logic [31:0]                   wbs_adr_i,
   output logic                          wbs_ack_o,
   output logic [31:0]                   wbs_dat_o,
   output logic [NUM_TEAMS:0]            designs_stb,
   output logic                          la_control_stb,
   output logic                          gpio_control_stb,
   output logic [31:0]                   adr_truncated,
   input  logic [32*(NUM_TEAMS+1)-1:0]   designs_wbs_dat_o_flat,
   input  logic [NUM_TEAMS:0]            designs_ack_o,
   input  logic [31:0]                   la_control_dat_o,
   input  logic [31:0]                   gpio_control_dat_o,
   input  logic                          la_control_ack_o,
   input  logic                          gpio_control_ack_o,
   output logic                          timeout_irq_o
);

   localparam logic [3:0] CODE_LA   = 4'hE;
   localparam logic [3:0] CODE_GPIO = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] adr_q, adr_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic        irq_q, irq_d;

   logic [3:0]  req_code;
   logic        req_mapped;
   logic        sel_ack;
   logic [31:0] sel_dat;
   logic        expired;
   logic        unused_ok;

   assign req_code = wbs_adr_i[19:16];

   always_comb begin
      req_mapped = 1'b0;
      if (req_code == CODE_LA || req_code == CODE_GPIO) begin
         req_mapped = 1'b1;
      end else if (req_code != 4'd0 && 32'(req_code) <= NUM_TEAMS) begin
         req_mapped = 1'b1;
      end
   end

   // Ack/data of the latched slave only; every other ack is ignored.
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      if (sel_q == CODE_LA) begin
         sel_ack = la_control_ack_o;
         sel_dat = la_control_dat_o;
      end else if (sel_q == CODE_GPIO) begin
         sel_ack = gpio_control_ack_o;
         sel_dat = gpio_control_dat_o;
      end else begin
         for (int unsigned i = 1; i <= NUM_TEAMS; i++) begin
            if (32'(sel_q) == i) begin
               sel_ack = designs_ack_o[i];
               sel_dat = designs_wbs_dat_o_flat[32*i +: 32];
            end
         end
      end
   end

   // Strobes are decoded from registered state, so they appear the cycle
   // after the request is sampled and clear asynchronously with reset.
   always_comb begin
      designs_stb      = '0;
      la_control_stb   = 1'b0;
      gpio_control_stb = 1'b0;
      if (state_q == ST_BUSY) begin
         if (sel_q == CODE_LA) begin
            la_control_stb = 1'b1;
         end else if (sel_q == CODE_GPIO) begin
            gpio_control_stb = 1'b1;
         end else begin
            for (int unsigned i = 1; i <= NUM_TEAMS; i++) begin
               designs_stb[i] = (32'(sel_q) == i);
            end
         end
      end
   end

`ifdef WB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter is zero outside BUSY, so it starts from 0 on every BUSY entry.
   assign expired = (32'(cnt_q) == TIMEOUT_CYCLES);

   always_comb begin
      cnt_d = '0;
      if (state_q == ST_BUSY) begin
         cnt_d = expired ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign unused_ok = ^{wbs_adr_i[31:20], designs_ack_o[0],
                        designs_wbs_dat_o_flat[31:0]};
`else
   assign expired   = 1'b0;
   assign unused_ok = ^{wbs_adr_i[31:20], designs_ack_o[0],
                        designs_wbs_dat_o_flat[31:0], 32'(TIMEOUT_CYCLES)};
`endif

   // Priority in BUSY: host abort, then slave ack, then timeout.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      irq_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               if (req_mapped) begin
                  sel_d   = req_code;
                  adr_d   = wbs_adr_i[15:0];
                  state_d = ST_BUSY;
               end else begin
                  dat_d   = ERR_DATA;
                  ack_d   = 1'b1;
                  state_d = ST_ACK;
               end
            end
         end
         ST_BUSY: begin
            if (!wbs_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sel_ack) begin
               dat_d   = sel_dat;
               ack_d   = 1'b1;
               state_d = ST_ACK;
            end else if (expired) begin
               dat_d   = ERR_DATA;
               ack_d   = 1'b1;
               irq_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         adr_q   <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         irq_q   <= irq_d;
      end
   end

   assign wbs_ack_o     = ack_q;
   assign wbs_dat_o     = dat_q;
   assign timeout_irq_o = irq_q;
   assign adr_truncated = {16'h0, adr_q};

endmodule

// File: tb/tb_wb_team_interconnect.sv
module tb_wb_team_interconnect;

   localparam int NT    = 3;
   localparam int TO    = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam int NEVER = 100000;

   logic                   wb_clk_i = 1'b0;
   logic                   wb_rst_ni;
   logic                   wbs_cyc_i;
   logic                   wbs_stb_i;
   logic [31:0]            wbs_adr_i;
   logic                   wbs_ack_o;
   logic [31:0]            wbs_dat_o;
   logic [NT:0]            designs_stb;
   logic                   la_control_stb;
   logic                   gpio_control_stb;
   logic [31:0]            adr_truncated;
   logic [32*(NT+1)-1:0]   designs_wbs_dat_o_flat;
   logic [NT:0]            designs_ack_o;
   logic [31:0]            la_control_dat_o;
   logic [31:0]            gpio_control_dat_o;
   logic                   la_control_ack_o;
   logic                   gpio_control_ack_o;
   logic                   timeout_irq_o;

   wb_team_interconnect #(
      .NUM_TEAMS      (NT),
      .TIMEOUT_CYCLES (TO),
      .ERR_DATA       (ERR)
   ) dut (
      .wb_clk_i               (wb_clk_i),
      .wb_rst_ni              (wb_rst_ni),
      .wbs_cyc_i              (wbs_cyc_i),
      .wbs_stb_i              (wbs_stb_i),
      .wbs_adr_i              (wbs_adr_i),
      .wbs_ack_o              (wbs_ack_o),
      .wbs_dat_o              (wbs_dat_o),
      .designs_stb            (designs_stb),
      .la_control_stb         (la_control_stb),
      .gpio_control_stb       (gpio_control_stb),
      .adr_truncated          (adr_truncated),
      .designs_wbs_dat_o_flat (designs_wbs_dat_o_flat),
      .designs_ack_o          (designs_ack_o),
      .la_control_dat_o       (la_control_dat_o),
      .gpio_control_dat_o     (gpio_control_dat_o),
      .la_control_ack_o       (la_control_ack_o),
      .gpio_control_ack_o     (gpio_control_ack_o),
      .timeout_irq_o          (timeout_irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_dat;
   logic [31:0] team_dat [NT+1];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ack"}, 32'(wbs_ack_o), 32'd0);
      check_eq({tag, "_dat"}, wbs_dat_o, 32'd0);
      check_eq({tag, "_stb"}, 32'({gpio_control_stb, la_control_stb, designs_stb}), 32'd0);
      check_eq({tag, "_adr"}, adr_truncated, 32'd0);
      check_eq({tag, "_irq"}, 32'(timeout_irq_o), 32'd0);
   endtask

   // stray: 0 = no other acks, 1 = random acks from other slaves,
   // 2 = every other slave acks continuously.
   // abort_req: -1 = none, -2 = random cycle, >=0 = cycle index after
   // which the host drops cyc.
   task automatic do_txn(input logic [31:0] adr, input int lat, input int abort_req,
                         input int stray, input bit use_val, input logic [31:0] sel_val);
      logic [3:0]    s;
      bit            mapped, exp_to, abort_v, acked, exp_ack, in_busy, drop;
      int            exp_edge, abort_at, end_edge, busy_end;
      logic [31:0]   exp_dat;
      logic [NT+2:0] exp_stb;
      logic [31:0]   la_v, gp_v;

      s = adr[19:16];
      mapped = (s >= 4'd1 && s <= 4'(NT)) || s == 4'hE || s == 4'hF;

      for (int i = 0; i <= NT; i++) team_dat[i] = $urandom;
      la_v = $urandom;
      gp_v = $urandom;
      if (use_val) begin
         if (s == 4'hE) la_v = sel_val;
         else if (s == 4'hF) gp_v = sel_val;
         else if (mapped) team_dat[int'(s)] = sel_val;
      end
      for (int i = 0; i <= NT; i++) designs_wbs_dat_o_flat[32*i +: 32] = team_dat[i];
      la_control_dat_o   = la_v;
      gpio_control_dat_o = gp_v;

      exp_to  = 1'b0;
      exp_stb = '0;
      if (!mapped) begin
         exp_edge = 0;
         exp_dat  = ERR;
      end else begin
         exp_edge = lat + 1;
         if (s == 4'hE) begin
            exp_dat = la_v;
            exp_stb[NT+1] = 1'b1;
         end else if (s == 4'hF) begin
            exp_dat = gp_v;
            exp_stb[NT+2] = 1'b1;
         end else begin
            exp_dat = team_dat[int'(s)];
            exp_stb[int'(s)] = 1'b1;
         end
`ifdef WB_TIMEOUT_EN
         if (exp_edge > TO + 1) begin
            exp_edge = TO + 1;
            exp_to   = 1'b1;
            exp_dat  = ERR;
         end
`endif
      end

      abort_at = abort_req;
      if (abort_req == -2 && mapped)
         abort_at = (exp_edge - 1 > 20) ? int'($urandom_range(0, 20))
                                        : int'($urandom_range(0, exp_edge - 1));
      abort_v  = mapped && abort_at >= 0 && abort_at + 1 <= exp_edge;
      end_edge = abort_v ? abort_at + 3 : exp_edge + 1;
      busy_end = abort_v ? abort_at + 1 : exp_edge;

      @(negedge wb_clk_i);
      wbs_adr_i = adr;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      acked = 1'b0;

      for (int k = 0; k <= end_edge; k++) begin
         @(posedge wb_clk_i);
         #1;
         exp_ack = !abort_v && k == exp_edge;
         if (exp_ack) acked = 1'b1;
         in_busy = mapped && k < busy_end;
         check_eq("ack", 32'(wbs_ack_o), 32'(exp_ack));
         check_eq("stb", 32'({gpio_control_stb, la_control_stb, designs_stb}),
                  in_busy ? 32'(exp_stb) : 32'd0);
         check_eq("dat", wbs_dat_o, acked ? exp_dat : last_dat);
         check_eq("irq", 32'(timeout_irq_o), 32'(exp_ack && exp_to));
         if (in_busy) check_eq("adr", adr_truncated, {16'h0, adr[15:0]});

         drop = abort_v ? (k >= abort_at) : (k >= exp_edge);
         wbs_cyc_i = !drop;
         wbs_stb_i = !drop;

         designs_ack_o      = '0;
         la_control_ack_o   = 1'b0;
         gpio_control_ack_o = 1'b0;
         if (stray == 1) begin
            designs_ack_o      = (NT+1)'($urandom);
            la_control_ack_o   = 1'($urandom);
            gpio_control_ack_o = 1'($urandom);
         end else if (stray == 2) begin
            designs_ack_o      = '1;
            la_control_ack_o   = 1'b1;
            gpio_control_ack_o = 1'b1;
         end
         if (mapped) begin
            if (s == 4'hE) la_control_ack_o = (k == lat);
            else if (s == 4'hF) gpio_control_ack_o = (k == lat);
            else designs_ack_o[int'(s)] = (k == lat);
         end
      end

      designs_ack_o      = '0;
      la_control_ack_o   = 1'b0;
      gpio_control_ack_o = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      if (acked) last_dat = exp_dat;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  s;
      logic [31:0] adr;
      int          lat, ab, r;

      wb_rst_ni              = 1'b0;
      wbs_cyc_i              = 1'b1;
      wbs_stb_i              = 1'b1;
      wbs_adr_i              = 32'h3001_0000;
      designs_wbs_dat_o_flat = '0;
      designs_ack_o          = '0;
      la_control_dat_o       = '0;
      gpio_control_dat_o     = '0;
      la_control_ack_o       = 1'b0;
      gpio_control_ack_o     = 1'b0;
      last_dat               = 32'd0;

      repeat (3) @(posedge wb_clk_i);
      #1;
      check_all_zero("reset");
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_all_zero("post_reset");

      do_txn(32'h3003_0010, 1, -1, 0, 1'b1, 32'h1234_5678);
      do_txn(32'h300F_0004, 0, -1, 0, 1'b0, 32'd0);
      do_txn(32'h300E_0100, 2, -1, 0, 1'b0, 32'd0);
      do_txn(32'h3000_0000, 0, -1, 0, 1'b0, 32'd0);
      do_txn(32'hFFF4_ABCD, 0, -1, 1, 1'b0, 32'd0);
`ifdef WB_TIMEOUT_EN
      do_txn(32'h3001_0000, NEVER, -1, 0, 1'b0, 32'd0);
      do_txn(32'h3001_0008, TO, -1, 0, 1'b0, 32'd0);
      do_txn(32'h3002_0008, TO + 1, -1, 0, 1'b0, 32'd0);
`else
      do_txn(32'h3001_0000, NEVER, 1000, 0, 1'b0, 32'd0);
`endif
      do_txn(32'h3002_0040, 5, 2, 0, 1'b0, 32'd0);
      do_txn(32'h3002_0044, 3, 3, 0, 1'b0, 32'd0);
      do_txn(32'h3001_0000, 4, -1, 2, 1'b0, 32'd0);

      // Reset in the middle of a BUSY transaction with the slave acking.
      @(negedge wb_clk_i);
      wbs_adr_i = 32'h3002_0020;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_eq("mid_stb", 32'({gpio_control_stb, la_control_stb, designs_stb}), 32'h04);
      designs_ack_o[2] = 1'b1;
      #2;
      wb_rst_ni = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      designs_ack_o = '0;
      wb_rst_ni = 1'b1;
      last_dat = 32'd0;
      repeat (2) begin
         @(posedge wb_clk_i);
         #1;
         check_all_zero("rst_release");
      end

      for (int t = 0; t < 250; t++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5) s = 4'($urandom_range(1, NT));
         else if (r == 6) s = 4'hE;
         else if (r == 7) s = 4'hF;
         else s = 4'($urandom_range(0, 15));
         adr = {12'($urandom), s, 16'($urandom)};
         lat = int'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(7, 12));
         ab = ($urandom_range(0, 4) == 0) ? -2 : -1;
         do_txn(adr, lat, ab, 1, 1'b0, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
